// File: rtl/lsu_ordered_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ordered_issue_queue
// Brief    : Age-ordered LSU issue queue with operand wakeup, one issue per
//            cycle, and load/store memory ordering.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ordered_issue_queue #(
    parameter int DEPTH        = 8,
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int WAKE_PORTS   = 4
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             flush,
    input  logic                                             inst_valid,
    output logic                                             queue_ready,
    input  logic [INST_ID_BITS-1:0]                          inst_id,
    input  logic [31:0]                                      raw_instr,
    input  logic [63:0]                                      instr_pc,
    input  logic                                             is_store,
    input  logic [MAX_OPERANDS-1:0]                          prn_input_valid,
    input  logic [MAX_OPERANDS-1:0]                          prn_input_ready,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            prn_input,
    input  logic [MAX_OPERANDS-1:0]                          prn_output_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            prn_output,
    input  logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0]          set_prn_ready,
    input  logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
    output logic                                             iss_valid,
    input  logic                                             iss_ready,
    output logic [INST_ID_BITS-1:0]                          iss_inst_id,
    output logic [31:0]                                      iss_raw_instr,
    output logic [63:0]                                      iss_instr_pc,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            iss_prn_input,
    output logic [MAX_OPERANDS-1:0]                          iss_prn_input_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            iss_prn_output,
    output logic [MAX_OPERANDS-1:0]                          iss_prn_output_valid,
    output logic [$clog2(DEPTH+1)-1:0]                       occupancy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]                         r_valid;
    logic [DEPTH-1:0]                         r_issued;
    logic [DEPTH-1:0]                         r_is_store;
    logic [MAX_OPERANDS-1:0]                  r_src_rdy [DEPTH];
    logic [INST_ID_BITS-1:0]                  r_id      [DEPTH];
    logic [31:0]                              r_raw     [DEPTH];
    logic [63:0]                              r_pc      [DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    r_src_prn [DEPTH];
    logic [MAX_OPERANDS-1:0]                  r_src_vld [DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    r_dst_prn [DEPTH];
    logic [MAX_OPERANDS-1:0]                  r_dst_vld [DEPTH];
    logic [c_PTR_W-1:0]                       r_head;
    logic [c_PTR_W-1:0]                       r_tail;
    logic [c_CNT_W-1:0]                       r_count;

    logic [MAX_OPERANDS-1:0]                  w_src_wake [DEPTH];
    logic [MAX_OPERANDS-1:0]                  w_new_wake;
    logic                                     w_sel_found;
    logic [c_PTR_W-1:0]                       w_sel_idx;
    logic                                     w_full;
    logic                                     w_enq;
    logic                                     w_fire;
    logic                                     w_retire;

    always_comb begin : p_wakeup
        w_new_wake = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_src_wake[e] = '0;
        end
        for (int s = 0; s < MAX_OPERANDS; s++) begin
            for (int w = 0; w < WAKE_PORTS; w++) begin
                for (int k = 0; k < MAX_OPERANDS; k++) begin
                    if (set_prn_ready[w][k] && (set_prn[w][k] == prn_input[s]))
                        w_new_wake[s] = 1'b1;
                    for (int e = 0; e < DEPTH; e++) begin
                        if (set_prn_ready[w][k] && (set_prn[w][k] == r_src_prn[e][s]))
                            w_src_wake[e][s] = 1'b1;
                    end
                end
            end
        end
    end

    // Age-ordered scan from head: a store needs no older unissued entry at all,
    // a load only needs no older unissued store.
    always_comb begin : p_select
        logic [c_PTR_W-1:0] w_idx;
        logic               w_older_store;
        logic               w_older_unissued;
        logic               w_elig;
        w_sel_found      = 1'b0;
        w_sel_idx        = '0;
        w_older_store    = 1'b0;
        w_older_unissued = 1'b0;
        w_idx            = '0;
        w_elig           = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + c_PTR_W'(i);
            if (r_valid[w_idx] && !r_issued[w_idx]) begin
                w_elig = (&r_src_rdy[w_idx]) &&
                         (r_is_store[w_idx] ? !w_older_unissued : !w_older_store);
                if (w_elig && !w_sel_found) begin
                    w_sel_found = 1'b1;
                    w_sel_idx   = w_idx;
                end
                w_older_unissued = 1'b1;
                if (r_is_store[w_idx])
                    w_older_store = 1'b1;
            end
        end
    end

    assign w_full      = (r_count == c_CNT_W'(DEPTH));
    assign queue_ready = !w_full;
    assign occupancy   = r_count;
    assign w_enq       = inst_valid && !w_full && !flush;
    assign w_retire    = r_valid[r_head] && r_issued[r_head];
    assign iss_valid   = w_sel_found && !flush;
    assign w_fire      = iss_valid && iss_ready;

    assign iss_inst_id          = w_sel_found ? r_id[w_sel_idx]      : '0;
    assign iss_raw_instr        = w_sel_found ? r_raw[w_sel_idx]     : '0;
    assign iss_instr_pc         = w_sel_found ? r_pc[w_sel_idx]      : '0;
    assign iss_prn_input        = w_sel_found ? r_src_prn[w_sel_idx] : '0;
    assign iss_prn_input_valid  = w_sel_found ? r_src_vld[w_sel_idx] : '0;
    assign iss_prn_output       = w_sel_found ? r_dst_prn[w_sel_idx] : '0;
    assign iss_prn_output_valid = w_sel_found ? r_dst_vld[w_sel_idx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= '0;
            r_issued   <= '0;
            r_is_store <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            for (int e = 0; e < DEPTH; e++) r_src_rdy[e] <= '0;
        end else if (flush) begin
            r_valid    <= '0;
            r_issued   <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            for (int e = 0; e < DEPTH; e++) r_src_rdy[e] <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++)
                r_src_rdy[e] <= r_src_rdy[e] | (w_src_wake[e] & {MAX_OPERANDS{r_valid[e]}});
            if (w_fire)
                r_issued[w_sel_idx] <= 1'b1;
            if (w_retire) begin
                r_valid[r_head]  <= 1'b0;
                r_issued[r_head] <= 1'b0;
                r_head           <= r_head + c_PTR_W'(1);
            end
            if (w_enq) begin
                r_valid[r_tail]    <= 1'b1;
                r_issued[r_tail]   <= 1'b0;
                r_is_store[r_tail] <= is_store;
                r_src_rdy[r_tail]  <= ~prn_input_valid | prn_input_ready | w_new_wake;
                r_tail             <= r_tail + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_retire);
        end
    end

    // Payload is only observed through a valid entry, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_id[r_tail]      <= inst_id;
            r_raw[r_tail]     <= raw_instr;
            r_pc[r_tail]      <= instr_pc;
            r_src_prn[r_tail] <= prn_input;
            r_src_vld[r_tail] <= prn_input_valid;
            r_dst_prn[r_tail] <= prn_output;
            r_dst_vld[r_tail] <= prn_output_valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ordered_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ordered_issue_queue
// Brief    : Directed self-checking bench for lsu_ordered_issue_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ordered_issue_queue;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  inst_valid;
    logic                  queue_ready;
    logic [5:0]            inst_id;
    logic [31:0]           raw_instr;
    logic [63:0]           instr_pc;
    logic                  is_store;
    logic [2:0]            prn_input_valid;
    logic [2:0]            prn_input_ready;
    logic [2:0][5:0]       prn_input;
    logic [2:0]            prn_output_valid;
    logic [2:0][5:0]       prn_output;
    logic [3:0][2:0]       set_prn_ready;
    logic [3:0][2:0][5:0]  set_prn;
    logic                  iss_valid;
    logic                  iss_ready;
    logic [5:0]            iss_inst_id;
    logic [31:0]           iss_raw_instr;
    logic [63:0]           iss_instr_pc;
    logic [2:0][5:0]       iss_prn_input;
    logic [2:0]            iss_prn_input_valid;
    logic [2:0][5:0]       iss_prn_output;
    logic [2:0]            iss_prn_output_valid;
    logic [3:0]            occupancy;

    int checks   = 0;
    int failures = 0;

    lsu_ordered_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inst_valid(inst_valid), .queue_ready(queue_ready),
        .inst_id(inst_id), .raw_instr(raw_instr), .instr_pc(instr_pc),
        .is_store(is_store),
        .prn_input_valid(prn_input_valid), .prn_input_ready(prn_input_ready),
        .prn_input(prn_input),
        .prn_output_valid(prn_output_valid), .prn_output(prn_output),
        .set_prn_ready(set_prn_ready), .set_prn(set_prn),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_inst_id(iss_inst_id), .iss_raw_instr(iss_raw_instr),
        .iss_instr_pc(iss_instr_pc),
        .iss_prn_input(iss_prn_input), .iss_prn_input_valid(iss_prn_input_valid),
        .iss_prn_output(iss_prn_output), .iss_prn_output_valid(iss_prn_output_valid),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; inst_valid = 1'b0; inst_id = '0; raw_instr = '0; instr_pc = '0;
        is_store = 1'b0; prn_input_valid = '0; prn_input_ready = '0; prn_input = '0;
        prn_output_valid = '0; prn_output = '0; set_prn_ready = '0; set_prn = '0;
    endtask

    // Source slot 0 carries prn0; a load also writes a destination equal to its id.
    task automatic drive_enq(input logic [5:0] id, input logic st, input logic src_v,
                             input logic src_r, input logic [5:0] prn0);
        inst_valid       = 1'b1;
        inst_id          = id;
        raw_instr        = 32'hA500_0000 | 32'(id);
        instr_pc         = 64'h0000_1000 + 64'(id) * 64'd4;
        is_store         = st;
        prn_input_valid  = {2'b00, src_v};
        prn_input_ready  = {2'b00, src_r};
        prn_input        = '0;
        prn_input[0]     = prn0;
        prn_output_valid = st ? 3'b000 : 3'b001;
        prn_output       = '0;
        prn_output[0]    = id;
    endtask

    task automatic test_reset();
        idle_inputs();
        iss_ready = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        tick(); tick();
        checks++; if (queue_ready !== 1'b1) begin failures++; $display("FAIL reset_queue_ready got=%0b exp=1", queue_ready); end
        checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL reset_iss_valid got=%0b exp=0", iss_valid); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        checks++; if (iss_inst_id !== 6'd0 || iss_instr_pc !== 64'd0) begin failures++; $display("FAIL reset_payload id=%0d pc=%0h exp=0", iss_inst_id, iss_instr_pc); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_load();
        iss_ready = 1'b1;
        drive_enq(6'd1, 1'b0, 1'b1, 1'b1, 6'd3);
        #1;
        checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL single_not_same_cycle got=%0b exp=0", iss_valid); end
        tick();
        idle_inputs();
        #1;
        checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd1) begin failures++; $display("FAIL single_issue valid=%0b id=%0d exp=1/1", iss_valid, iss_inst_id); end
        checks++; if (iss_raw_instr !== 32'hA500_0001 || iss_instr_pc !== 64'h1004) begin failures++; $display("FAIL single_payload raw=%0h pc=%0h exp=a5000001/1004", iss_raw_instr, iss_instr_pc); end
        checks++; if (iss_prn_input !== 18'd3 || iss_prn_input_valid !== 3'b001 || iss_prn_output_valid !== 3'b001 || iss_prn_output !== 18'd1) begin failures++; $display("FAIL single_prns in=%0h inv=%0b out=%0h outv=%0b", iss_prn_input, iss_prn_input_valid, iss_prn_output, iss_prn_output_valid); end
        checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL single_occ1 got=%0d exp=1", occupancy); end
        tick();
        checks++; if (iss_valid !== 1'b0 || occupancy !== 4'd1) begin failures++; $display("FAIL single_after_issue valid=%0b occ=%0d exp=0/1", iss_valid, occupancy); end
        tick();
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL single_retired got=%0d exp=0", occupancy); end
    endtask

    task automatic test_full();
        iss_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_enq(6'(10 + i), 1'b0, 1'b0, 1'b0, 6'd0);
            #1;
            checks++; if (queue_ready !== 1'b1) begin failures++; $display("FAIL full_ready_before i=%0d got=%0b exp=1", i, queue_ready); end
            tick();
        end
        drive_enq(6'd18, 1'b0, 1'b0, 1'b0, 6'd0);
        #1;
        checks++; if (queue_ready !== 1'b0 || occupancy !== 4'd8) begin failures++; $display("FAIL full_flag ready=%0b occ=%0d exp=0/8", queue_ready, occupancy); end
        tick();
        idle_inputs();
        checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL full_ninth_ignored occ=%0d exp=8", occupancy); end
        iss_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'(10 + i)) begin failures++; $display("FAIL full_drain i=%0d valid=%0b id=%0d exp=%0d", i, iss_valid, iss_inst_id, 10 + i); end
            tick();
        end
        checks++; if (iss_valid !== 1'b0 || occupancy !== 4'd1) begin failures++; $display("FAIL full_no_ninth valid=%0b occ=%0d exp=0/1", iss_valid, occupancy); end
        tick();
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL full_empty occ=%0d exp=0", occupancy); end
    endtask

    task automatic test_store_order();
        iss_ready = 1'b1;
        drive_enq(6'd20, 1'b1, 1'b1, 1'b0, 6'd5);
        tick();
        drive_enq(6'd21, 1'b0, 1'b1, 1'b1, 6'd9);
        #1;
        checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL st_store_waits got=%0b exp=0", iss_valid); end
        tick();
        idle_inputs();
        #1;
        checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL st_load_held got=%0b exp=0", iss_valid); end
        tick();
        set_prn_ready[2][0] = 1'b1;
        set_prn[2][0] = 6'd5;
        #1;
        checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL st_wake_registered got=%0b exp=0", iss_valid); end
        tick();
        idle_inputs();
        #1;
        checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd20) begin failures++; $display("FAIL st_store_issue valid=%0b id=%0d exp=1/20", iss_valid, iss_inst_id); end
        tick();
        checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd21) begin failures++; $display("FAIL st_load_issue valid=%0b id=%0d exp=1/21", iss_valid, iss_inst_id); end
        tick();
        tick();
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL st_empty occ=%0d exp=0", occupancy); end
    endtask

    task automatic test_out_of_order_loads();
        iss_ready = 1'b0;
        drive_enq(6'd30, 1'b0, 1'b1, 1'b0, 6'd7);
        tick();
        drive_enq(6'd31, 1'b0, 1'b1, 1'b1, 6'd8);
        tick();
        idle_inputs();
        iss_ready = 1'b1;
        #1;
        checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd31) begin failures++; $display("FAIL ooo_younger_first valid=%0b id=%0d exp=1/31", iss_valid, iss_inst_id); end
        tick();
        checks++; if (iss_valid !== 1'b0 || occupancy !== 4'd2) begin failures++; $display("FAIL ooo_wait valid=%0b occ=%0d exp=0/2", iss_valid, occupancy); end
        tick();
        checks++; if (occupancy !== 4'd2) begin failures++; $display("FAIL ooo_no_retire occ=%0d exp=2", occupancy); end
        set_prn_ready[0][1] = 1'b1;
        set_prn[0][1] = 6'd7;
        tick();
        idle_inputs();
        #1;
        checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd30) begin failures++; $display("FAIL ooo_older_issue valid=%0b id=%0d exp=1/30", iss_valid, iss_inst_id); end
        tick();
        tick();
        checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL ooo_retire1 occ=%0d exp=1", occupancy); end
        tick();
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL ooo_retire2 occ=%0d exp=0", occupancy); end
    endtask

    task automatic test_back_to_back();
        iss_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_enq(6'(40 + i), 1'b0, 1'b0, 1'b0, 6'd0);
            #1;
            checks++; if (queue_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%0b exp=1", i, queue_ready); end
            if (i > 0) begin
                checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'(39 + i)) begin failures++; $display("FAIL b2b_order i=%0d valid=%0b id=%0d exp=%0d", i, iss_valid, iss_inst_id, 39 + i); end
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd59) begin failures++; $display("FAIL b2b_last valid=%0b id=%0d exp=1/59", iss_valid, iss_inst_id); end
        tick();
        checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%0b exp=0", iss_valid); end
        tick(); tick();
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL b2b_empty occ=%0d exp=0", occupancy); end
    endtask

    task automatic test_flush();
        iss_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_enq(6'(60 + i), 1'b0, 1'b0, 1'b0, 6'd0);
            tick();
        end
        idle_inputs();
        #1;
        checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd60 || occupancy !== 4'd5) begin failures++; $display("FAIL flush_pre valid=%0b id=%0d occ=%0d exp=1/60/5", iss_valid, iss_inst_id, occupancy); end
        drive_enq(6'd1, 1'b0, 1'b0, 1'b0, 6'd0);
        flush = 1'b1;
        iss_ready = 1'b1;
        #1;
        checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL flush_iss_forced got=%0b exp=0", iss_valid); end
        tick();
        idle_inputs();
        #1;
        checks++; if (occupancy !== 4'd0 || queue_ready !== 1'b1 || iss_valid !== 1'b0) begin failures++; $display("FAIL flush_cleared occ=%0d ready=%0b valid=%0b exp=0/1/0", occupancy, queue_ready, iss_valid); end
        tick();
        checks++; if (iss_valid !== 1'b0 || occupancy !== 4'd0) begin failures++; $display("FAIL flush_enq_dropped valid=%0b occ=%0d exp=0/0", iss_valid, occupancy); end
    endtask

    task automatic test_reset_mid();
        iss_ready = 1'b0;
        drive_enq(6'd50, 1'b0, 1'b0, 1'b0, 6'd0);
        tick();
        drive_enq(6'd51, 1'b1, 1'b0, 1'b0, 6'd0);
        tick();
        idle_inputs();
        #2 rst = 1'b0;
        #1;
        checks++; if (occupancy !== 4'd0 || iss_valid !== 1'b0 || queue_ready !== 1'b1) begin failures++; $display("FAIL midreset occ=%0d valid=%0b ready=%0b exp=0/0/1", occupancy, iss_valid, queue_ready); end
        tick();
        rst = 1'b1;
        iss_ready = 1'b1;
        tick();
        checks++; if (iss_valid !== 1'b0 || occupancy !== 4'd0) begin failures++; $display("FAIL midreset_after valid=%0b occ=%0d exp=0/0", iss_valid, occupancy); end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_full();
        test_store_order();
        test_out_of_order_loads();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
